// File: rtl/dmaster_st_packet_arbiter.sv
// rtl/dmaster_st_packet_arbiter.sv - packet-atomic round-robin Avalon-ST arbiter with channel tagging
// Optional: DMASTER_ARB_CH0_PRIORITY_EN gives input 0 absolute priority at arbitration.
module dmaster_st_packet_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CH_W-1:0]          out_channel,
  output logic                     busy
);

  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, last_grant, win, pos;
  logic            win_found;
  logic            accept;
  logic            out_free;
  logic [DATA_W-1:0] data_arr [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_slice
    assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Scan downward so the closest requester after last_grant is the final overwrite.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    pos       = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      pos = GW'((int'(last_grant) + k) % NUM_IN);
      if (in_valid[pos]) begin
        win       = pos;
        win_found = 1'b1;
      end
    end
`ifdef DMASTER_ARB_CH0_PRIORITY_EN
    if (in_valid[0]) begin
      win       = '0;
      win_found = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_found) state_nxt = LOCK;
      LOCK: if (accept && in_endofpacket[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is derived from state and the output register only, never from in_valid.
  always_comb begin
    in_ready = '0;
    out_free = !out_valid || out_ready;
    if (state == LOCK) in_ready[grant] = out_free;
    accept   = (state == LOCK) && in_valid[grant] && out_free;
    busy     = (state == LOCK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= GW'(NUM_IN - 1);
    end else if (state == IDLE && win_found) begin
      grant <= win;
`ifdef DMASTER_ARB_CH0_PRIORITY_EN
      if (win != '0) last_grant <= win;
`else
      last_grant <= win;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_data          <= data_arr[grant];
      out_startofpacket <= in_startofpacket[grant];
      out_endofpacket   <= in_endofpacket[grant];
      out_channel       <= CH_W'(grant);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmaster_st_packet_arbiter.sv
// tb/tb_dmaster_st_packet_arbiter.sv - directed bench for dmaster_st_packet_arbiter
// Per-cycle vector table for single-source framing, packet-source model for multi-input sequences.
module tb_dmaster_st_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_startofpacket = '0;
  logic [3:0]  in_endofpacket = '0;
  logic [3:0]  in_ready;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [7:0]  out_channel;
  logic        busy;

  int checks = 0;
  int failures = 0;

  dmaster_st_packet_arbiter #(.NUM_IN(4), .DATA_W(8), .CH_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_channel(out_channel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       ordy;
    logic       x_rdy;
    logic       x_busy;
    logic       x_ov;
    logic [7:0] x_od;
    logic       x_sop;
    logic       x_eop;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    int         cyc;
  } beat_t;

  vec_t  tv [11];
  beat_t log_q [$];
  beat_t exp_q [$];

  logic [7:0] pdata [4][8];
  int plen [4];
  int prep [4];
  int pos  [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      plen[i] = 0;
      prep[i] = 0;
      pos[i]  = 0;
      for (int j = 0; j < 8; j++) pdata[i][j] = '0;
    end
    in_valid = '0;
    in_data = '0;
    in_startofpacket = '0;
    in_endofpacket = '0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_sources();
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < 4; i++) begin
      if (prep[i] > 0) begin
        in_valid[i] = 1'b1;
        in_data[i*8 +: 8] = pdata[i][pos[i]];
        in_startofpacket[i] = (pos[i] == 0);
        in_endofpacket[i] = (pos[i] == plen[i] - 1);
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*8 +: 8] = '0;
        in_startofpacket[i] = 1'b0;
        in_endofpacket[i] = 1'b0;
      end
    end
  endtask

  // Cycle c: drive, observe at negedge, clock, advance sources that transferred.
  task automatic run(input int ncyc, input int st_lo, input int st_hi);
    logic [3:0]  fired;
    logic [17:0] snap;
    bit          in_stall;
    in_stall = 0;
    snap = '0;
    for (int c = 0; c < ncyc; c++) begin
      drive_sources();
      out_ready = !(c >= st_lo && c < st_hi);
      @(negedge clk);
      fired = in_valid & in_ready;
      if (out_valid && out_ready)
        log_q.push_back('{int'(out_channel), out_data, out_startofpacket, out_endofpacket, c});
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        if (in_stall)
          chk("stall_hold", 32'({out_data, out_startofpacket, out_endofpacket, out_channel}), 32'(snap));
        else begin
          snap = {out_data, out_startofpacket, out_endofpacket, out_channel};
          in_stall = 1;
        end
      end else begin
        in_stall = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fired[i]) begin
          if (pos[i] == plen[i] - 1) begin
            pos[i] = 0;
            prep[i]--;
          end else begin
            pos[i]++;
          end
        end
      end
    end
    drive_sources();
  endtask

  task automatic exp_add(input int ch, input logic [7:0] d, input logic s, input logic e);
    exp_q.push_back('{ch, d, s, e, 0});
  endtask

  task automatic cmp_log(input string name);
    int n;
    chk({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_ch"},   32'(log_q[i].ch),  32'(exp_q[i].ch));
      chk({name, "_data"}, 32'(log_q[i].d),   32'(exp_q[i].d));
      chk({name, "_sop"},  32'(log_q[i].sop), 32'(exp_q[i].sop));
      chk({name, "_eop"},  32'(log_q[i].eop), 32'(exp_q[i].eop));
    end
  endtask

  initial begin
    int rr_cyc [8];
    rr_cyc = '{2, 3, 5, 6, 8, 9, 11, 12};

    //           v  d      s  e  ordy rdy bsy ov od     osop oeop
    tv[0]  = '{1, 8'h11, 1, 0, 1,   0,  0,  0, 8'h00, 0,   0};
    tv[1]  = '{1, 8'h11, 1, 0, 1,   1,  1,  0, 8'h00, 0,   0};
    tv[2]  = '{1, 8'h22, 0, 0, 1,   1,  1,  1, 8'h11, 1,   0};
    tv[3]  = '{1, 8'h33, 0, 1, 1,   1,  1,  1, 8'h22, 0,   0};
    tv[4]  = '{0, 8'h00, 0, 0, 1,   0,  0,  1, 8'h33, 0,   1};
    tv[5]  = '{0, 8'h00, 0, 0, 1,   0,  0,  0, 8'h33, 0,   1};
    tv[6]  = '{1, 8'h44, 1, 1, 0,   0,  0,  0, 8'h33, 0,   1};
    tv[7]  = '{1, 8'h44, 1, 1, 0,   1,  1,  0, 8'h33, 0,   1};
    tv[8]  = '{0, 8'h00, 0, 0, 0,   0,  0,  1, 8'h44, 1,   1};
    tv[9]  = '{0, 8'h00, 0, 0, 1,   0,  0,  1, 8'h44, 1,   1};
    tv[10] = '{0, 8'h00, 0, 0, 1,   0,  0,  0, 8'h44, 1,   1};

    // Reset state
    clear_sources();
    in_valid = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_fields", 32'({out_data, out_startofpacket, out_endofpacket, out_channel}), 32'h0);

    // Single source, 3-beat packet then a single-beat packet under backpressure
    do_reset();
    for (int v = 0; v < 11; v++) begin
      in_valid = {3'b000, tv[v].v};
      in_data = {24'h0, tv[v].d};
      in_startofpacket = {3'b000, tv[v].s};
      in_endofpacket = {3'b000, tv[v].e};
      out_ready = tv[v].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'({3'b000, tv[v].x_rdy}));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'(tv[v].x_busy));
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(tv[v].x_ov));
      chk($sformatf("v%0d_out_data", v), 32'(out_data), 32'(tv[v].x_od));
      chk($sformatf("v%0d_sop_eop", v), 32'({out_startofpacket, out_endofpacket}),
          32'({tv[v].x_sop, tv[v].x_eop}));
      chk($sformatf("v%0d_channel", v), 32'(out_channel), 32'h0);
      @(posedge clk);
      #1;
    end

    // All four inputs with 2-beat packets: round robin 0..3 with one bubble per packet
    do_reset();
    for (int i = 0; i < 4; i++) begin
      plen[i] = 2;
      prep[i] = 1;
      pdata[i][0] = 8'(8'h30 + 8'(i * 16));
      pdata[i][1] = 8'(8'h31 + 8'(i * 16));
      exp_add(i, pdata[i][0], 1, 0);
      exp_add(i, pdata[i][1], 0, 1);
    end
    run(14, 0, 0);
    cmp_log("rr");
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("rr_cycle", 32'(log_q[i].cyc), 32'(rr_cyc[i]));

    // Input 2 stalled mid-packet for 5 cycles
    do_reset();
    plen[2] = 4;
    prep[2] = 1;
    for (int j = 0; j < 4; j++) begin
      pdata[2][j] = 8'(8'hB0 + j);
      exp_add(2, pdata[2][j], j == 0, j == 3);
    end
    run(12, 3, 8);
    cmp_log("stall");

    // Single-beat packet on input 1 while input 3 requests
    do_reset();
    plen[1] = 1;  prep[1] = 1;  pdata[1][0] = 8'hA1;
    plen[3] = 2;  prep[3] = 1;  pdata[3][0] = 8'hC1;  pdata[3][1] = 8'hC2;
    exp_add(1, 8'hA1, 1, 1);
    exp_add(3, 8'hC1, 1, 0);
    exp_add(3, 8'hC2, 0, 1);
    run(10, 0, 0);
    cmp_log("single");
    if (log_q.size() >= 2) begin
      chk("single_cyc0", 32'(log_q[0].cyc), 32'd2);
      chk("single_cyc1", 32'(log_q[1].cyc), 32'd4);
    end

    // Asynchronous reset during the second beat of a 4-beat packet
    do_reset();
    plen[0] = 4;
    prep[0] = 1;
    for (int j = 0; j < 4; j++) pdata[0][j] = 8'(8'h51 + j);
    run(2, 0, 0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    clear_sources();
    @(posedge clk);
    #1 reset = 1'b0;
    plen[0] = 2;  prep[0] = 1;  pdata[0][0] = 8'h61;  pdata[0][1] = 8'h62;
    plen[1] = 2;  prep[1] = 1;  pdata[1][0] = 8'h71;  pdata[1][1] = 8'h72;
    exp_add(0, 8'h61, 1, 0);
    exp_add(0, 8'h62, 0, 1);
    exp_add(1, 8'h71, 1, 0);
    exp_add(1, 8'h72, 0, 1);
    run(10, 0, 0);
    cmp_log("post_rst");

    // Inputs 0 and 2 requesting back to back
    do_reset();
    plen[0] = 1;  prep[0] = 3;  pdata[0][0] = 8'h0A;
    plen[2] = 1;  prep[2] = 1;  pdata[2][0] = 8'h2A;
`ifdef DMASTER_ARB_CH0_PRIORITY_EN
    exp_add(0, 8'h0A, 1, 1);
    exp_add(0, 8'h0A, 1, 1);
    exp_add(0, 8'h0A, 1, 1);
    exp_add(2, 8'h2A, 1, 1);
`else
    exp_add(0, 8'h0A, 1, 1);
    exp_add(2, 8'h2A, 1, 1);
    exp_add(0, 8'h0A, 1, 1);
    exp_add(0, 8'h0A, 1, 1);
`endif
    run(12, 0, 0);
    cmp_log("ch0_order");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmaster_st_packet_arbiter.md
Name: dmaster_st_packet_arbiter

Overview:
- Shares one Avalon-ST byte stream between NUM_IN packet sources feeding the debug-master packet path.
- Arbitration is packet-atomic and round-robin.
- Tags every output beat with the source index on out_channel, so downstream channel-aware logic can route responses back.
- One registered output stage; the arbiter sits in front of the packets-to-bytes conversion path.

Parameters:
- NUM_IN, 4, number of requesting input streams (2..8)
- DATA_W, 8, symbol/data width in bits
- CH_W, 8, out_channel width; must satisfy 2**CH_W >= NUM_IN

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NUM_IN  per-input valid
- in_data  in  NUM_IN*DATA_W  per-input data; input i occupies bits [i*DATA_W +: DATA_W]
- in_startofpacket  in  NUM_IN  per-input SOP
- in_endofpacket  in  NUM_IN  per-input EOP
- in_ready  out  NUM_IN  per-input ready
- out_ready  in  1  downstream ready
- out_valid  out  1  registered output valid
- out_data  out  DATA_W  registered output data
- out_startofpacket  out  1  registered SOP
- out_endofpacket  out  1  registered EOP
- out_channel  out  CH_W  granted input index, zero-extended
- busy  out  1  high while a packet lock is held

Behaviour:
- Reset values: all outputs 0; state=IDLE; grant=0; last_grant=NUM_IN-1, so input 0 wins first.
- States:
  - IDLE: arbitrate. If any in_valid is set, the winner is the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_IN. Next cycle: grant=winner, last_grant=winner, state=LOCK. No beat is accepted in IDLE (one arbitration bubble per packet).
  - LOCK: in_ready[grant] = (!out_valid || out_ready); every other in_ready is 0.
    - Accepted beat (in_valid[grant] && in_ready[grant]): loads out_* on the next edge with out_channel=grant.
    - Accepting a beat with in_endofpacket[grant]=1 returns state to IDLE on that same edge.
- Output register: if out_valid && !out_ready, hold all out_* stable (no change while stalled). If out_ready && no new beat, clear out_valid. out_data, out_startofpacket, out_endofpacket and out_channel are don't-care while out_valid=0, but the implementation holds their last values.
- Latency: accepted beat appears on out_* 1 cycle later. Full-rate streaming inside a packet when out_ready=1.
- SOP/EOP: passed through unmodified; the arbiter does not repair framing. Lock release is driven only by the accepted EOP beat.
- Single-beat packet (SOP and EOP on the same beat): lock, forward, release, 2-cycle minimum per packet.
- in_valid dropping mid-packet: lock is held and other inputs wait indefinitely.
- Simultaneous requests: resolved strictly by round-robin order; an input that just finished has lowest priority next round.
- busy = (state==LOCK).
- Reset mid-packet: lock dropped, out_valid cleared immediately (async); the partial packet is not completed.
- in_ready never depends combinationally on in_valid.

Optional Feature:
- Macro: DMASTER_ARB_CH0_PRIORITY_EN.
- Defined: in IDLE, input 0 wins whenever in_valid[0]=1, regardless of last_grant; other inputs remain round-robin among themselves. last_grant is updated only when a non-zero input wins.
- Undefined: pure round-robin as above.

Test Plan:
- Reset released, in_valid=4'b0001, 3-beat packet 0x11/0x22/0x33 on input 0, out_ready=1 -> busy rises cycle 1; out beats 0x11 (SOP), 0x22, 0x33 (EOP) on consecutive cycles, out_channel=0; busy falls after EOP accepted.
- All four inputs valid, each with a 2-beat packet -> grants in order 0,1,2,3; one IDLE bubble between packets; out_channel sequence 0,0,1,1,2,2,3,3.
- Input 2 mid-packet, out_ready held 0 for 5 cycles -> out_data held stable, in_ready[2]=0 during the stall, no beat lost or duplicated once out_ready returns.
- Input 1 single-beat packet (SOP=EOP=1) while input 3 is requesting -> input 1 forwarded with both flags set, then input 3 granted next round.
- Reset asserted during the 2nd beat of a 4-beat packet -> out_valid=0 and busy=0 immediately; after release input 0 wins first.
- With DMASTER_ARB_CH0_PRIORITY_EN defined, inputs 0 and 2 valid continuously -> input 0 wins every arbitration; input 2 is granted only when in_valid[0]=0 at arbitration.
